secuenciador_lectura_rtc: RTL
=============================

# secuenciador_lectura_rtc

Sequencer that sweeps the six BCD time/date registers of the RTC through the bus interface's request/acknowledge port. It converts each returned BCD byte to 7-bit binary, range-checks it and stores it in a registered binary time bank. The bank feeds the display and arithmetic logic. One sweep runs per `iniciar` pulse; field faults and bus timeouts are reported without corrupting previously valid values.

## Interface
- `DIR_BASE`, default 8'h21: RTC address of the seconds register. Fields follow at consecutive addresses: seg, min, hora, dia, mes, anio.
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for `ack` per field (1..255).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: system clock; everything is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `iniciar`, input, 1: start-sweep pulse; sampled only in REPOSO.
- `req`, output, 1: read request to the bus interface.
- `dir`, output, 8: RTC register address; valid while `req`=1.
- `ack`, input, 1: read complete; `dato_bcd` is valid in the same cycle.
- `dato_bcd`, input, 8: BCD byte returned by the RTC.
- `ocupado`, output, 1: high whenever the FSM is not in REPOSO.
- `seg`, `min`, `hora`, `dia`, `mes`, `anio`, output, 7 each: stored binary values.
- `listo`, output, 1: one-cycle pulse at the end of a completed sweep.
- `error`, output, 6: per-field fault, bit0=seg … bit5=anio.
- `timeout`, output, 1: the sweep was aborted because `ack` never arrived.

## Operation
- FSM states: REPOSO, ESPERAR, CONVERTIR, FIN.
- REPOSO:
  - `req`=0, `dir`=8'h00.
  - When `iniciar`=1: clear `error` and `timeout`, set field index to 0, go to ESPERAR.
- ESPERAR:
  - `req`=1, `dir`=DIR_BASE+index, wait counter increments every cycle.
  - When `ack`=1: capture `dato_bcd`, go to CONVERTIR.
  - When the counter reaches TIMEOUT without `ack`: set `timeout`, go to REPOSO. No `listo`, remaining fields untouched.
- CONVERTIR:
  - `req`=0. Convert: if either nibble is >9, the result is 7'h7F; otherwise the result is 10×high nibble + low nibble.
  - Valid ranges: seg 0–59, min 0–59, hora 0–23, dia 1–31, mes 1–12, anio 0–99.
  - In range: write the field register. Out of range (including 7'h7F): keep the old value and set the error bit.
  - Then index+1, back to ESPERAR with the counter cleared. After index 5, go to FIN.
- FIN: `listo`=1 for exactly one cycle, then REPOSO. `listo` pulses even if some error bits are set.
- `iniciar` while `ocupado`=1 is ignored and does not restart the sweep.
- `ack` outside ESPERAR is ignored.

## Timing
- Reset values: `req`=0, `dir`=8'h00, all six fields=7'd0, `listo`=0, `error`=6'b0, `timeout`=0, `ocupado`=0, FSM=REPOSO, index=0.
- An `iniciar` sampled at edge k gives `req`=1 and `dir`=DIR_BASE from cycle k+1.
- An `ack` sampled at edge m gives:
  - `req`=0 in cycle m+1;
  - field register updated at edge m+1;
  - next `req` from cycle m+2.
- Cycles per field = cycles spent in ESPERAR + 1. `req` always drops for at least one cycle between fields.
- `dir` stays stable for the whole time `req` is high.
- `error` and `timeout` are sticky until the next accepted `iniciar`.
- Reset asserted mid-sweep: outputs go to their reset values immediately (asynchronously). No partial `listo`.
- Field outputs only change in CONVERTIR. Each output is registered and glitch-free.

## Test plan
- Responder acks in the 2nd cycle of each `req` with 12,34,09,28,02,17 (BCD) → `req` addresses 21..26 in order, seg=12, min=34, hora=9, dia=28, mes=2, anio=17. `listo` pulses once, 19 cycles after the `iniciar` edge. `error`=0.
- Sweep 1 stores valid values; sweep 2 returns seg=8'h60, hora=8'h1A, mes=8'h00 → error=6'b010101, seg/hora/mes keep their sweep-1 values, other fields updated, `listo` pulses.
- Responder never acks the min read (`TIMEOUT`=16) → `req` is high for 16 cycles, `timeout`=1, `listo` never pulses, seg updated, min..anio unchanged, `ocupado` drops.
- `iniciar` pulsed again during ESPERAR of field 3 → ignored: addresses continue 24,25,26 and exactly one `listo`.
- Reset asserted while in CONVERTIR of field 2 → all outputs equal reset values within that cycle. The next `iniciar` starts again at `dir`=8'h21.
- Boundary values 00,59,23,31,12,99 and then 59,00,00,01,01,00 → first set fully accepted. Second set: hora=0 and anio=0 accepted, dia=1 and mes=1 accepted, `error`=0.

Source files
------------

// File: rtl/secuenciador_lectura_rtc_if.sv
// Read port between the RTC sweep sequencer and the bus interface.
//   req      : read request, held until ack or abort
//   dir      : RTC register address, stable while req=1
//   ack      : read complete, dato_bcd valid in the same cycle
//   dato_bcd : BCD byte returned by the RTC
// master = sequencer side, slave = bus interface side.
interface secuenciador_lectura_rtc_if;
    logic       req;
    logic [7:0] dir;
    logic       ack;
    logic [7:0] dato_bcd;

    modport master (output req, output dir, input ack, input dato_bcd);
    modport slave  (input req, input dir, output ack, output dato_bcd);
endinterface

// File: rtl/secuenciador_lectura_rtc.sv
// RTC read sequencer: on each iniciar pulse it reads the six BCD time/date
// registers (seg, min, hora, dia, mes, anio) at DIR_BASE..DIR_BASE+5,
// converts them to binary, range-checks them and updates a registered
// binary bank. Bad fields keep their old value and flag an error bit; a
// missing ack aborts the sweep with timeout.
//   clk, reset   : clock, asynchronous active-low reset
//   iniciar      : start pulse, only honoured while idle
//   bus          : req/dir/ack/dato_bcd read port (master side)
//   ocupado      : sweep in progress
//   seg..anio    : stored binary fields
//   listo        : one-cycle pulse at the end of a completed sweep
//   error        : sticky per-field fault, bit0=seg .. bit5=anio
//   timeout      : sticky, sweep aborted waiting for ack
module secuenciador_lectura_rtc #(
    parameter logic [7:0] DIR_BASE = 8'h21,
    parameter logic [7:0] TIMEOUT  = 8'd255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        iniciar,
    secuenciador_lectura_rtc_if.master  bus,
    output logic                        ocupado,
    output logic [6:0]                  seg,
    output logic [6:0]                  min,
    output logic [6:0]                  hora,
    output logic [6:0]                  dia,
    output logic [6:0]                  mes,
    output logic [6:0]                  anio,
    output logic                        listo,
    output logic [5:0]                  error,
    output logic                        timeout
);

    typedef enum logic [1:0] {REPOSO, ESPERAR, CONVERTIR, FIN} estado_t;

    estado_t          state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       dato_q, dato_d;
    logic [5:0][6:0]  campo_q, campo_d;
    logic [5:0]       error_q, error_d;
    logic             timeout_q, timeout_d;
    logic             req_q, req_d;
    logic [7:0]       dir_q, dir_d;
    logic             listo_q, listo_d;
    logic             ocupado_q, ocupado_d;

    // Last wait cycle: counter starts at 0 on the first ESPERAR cycle, so
    // req stays high for exactly TIMEOUT cycles before aborting.
    logic espera_agotada;
    assign espera_agotada = (cnt_q == TIMEOUT - 8'd1);

    // BCD to binary on the captured byte; any non-decimal nibble maps to
    // 7'h7F, which is outside every field range.
    logic [3:0] nib_h, nib_l;
    logic [6:0] bin;
    assign nib_h = dato_q[7:4];
    assign nib_l = dato_q[3:0];

    always_comb begin
        if (nib_h > 4'd9 || nib_l > 4'd9)
            bin = 7'h7F;
        else
            bin = {nib_h, 3'b000} + {2'b00, nib_h, 1'b0} + {3'b000, nib_l};
    end

    // Per-field valid range
    logic [6:0] lim_min, lim_max;
    logic       en_rango;

    always_comb begin
        lim_min = 7'd0;
        lim_max = 7'd0;
        case (idx_q)
            3'd0:    begin lim_min = 7'd0; lim_max = 7'd59; end
            3'd1:    begin lim_min = 7'd0; lim_max = 7'd59; end
            3'd2:    begin lim_min = 7'd0; lim_max = 7'd23; end
            3'd3:    begin lim_min = 7'd1; lim_max = 7'd31; end
            3'd4:    begin lim_min = 7'd1; lim_max = 7'd12; end
            3'd5:    begin lim_min = 7'd0; lim_max = 7'd99; end
            default: begin lim_min = 7'd0; lim_max = 7'd0;  end
        endcase
    end

    assign en_rango = (bin >= lim_min) && (bin <= lim_max);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= REPOSO;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOSO:    if (iniciar) state_d = ESPERAR;
            ESPERAR: begin
                if (bus.ack)             state_d = CONVERTIR;
                else if (espera_agotada) state_d = REPOSO;
            end
            CONVERTIR: state_d = (idx_q == 3'd5) ? FIN : ESPERAR;
            FIN:       state_d = REPOSO;
            default:   state_d = REPOSO;
        endcase
    end

    // Datapath and outputs; req/dir/listo/ocupado are decoded from the
    // next state so they leave flops aligned with the state they describe.
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dato_d    = dato_q;
        campo_d   = campo_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        case (state_q)
            REPOSO: begin
                if (iniciar) begin
                    error_d   = 6'b0;
                    timeout_d = 1'b0;
                    idx_d     = 3'd0;
                    cnt_d     = 8'd0;
                end
            end
            ESPERAR: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.ack)             dato_d    = bus.dato_bcd;
                else if (espera_agotada) timeout_d = 1'b1;
            end
            CONVERTIR: begin
                for (int i = 0; i < 6; i++) begin
                    if (idx_q == 3'(i)) begin
                        if (en_rango) campo_d[i] = bin;
                        else          error_d[i] = 1'b1;
                    end
                end
                idx_d = idx_q + 3'd1;
                cnt_d = 8'd0;
            end
            default: ;
        endcase

        req_d     = (state_d == ESPERAR);
        dir_d     = req_d ? DIR_BASE + {5'b0, idx_d} : 8'h00;
        listo_d   = (state_d == FIN);
        ocupado_d = (state_d != REPOSO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            dato_q    <= 8'h00;
            campo_q   <= '0;
            error_q   <= 6'b0;
            timeout_q <= 1'b0;
            req_q     <= 1'b0;
            dir_q     <= 8'h00;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dato_q    <= dato_d;
            campo_q   <= campo_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            req_q     <= req_d;
            dir_q     <= dir_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.req = req_q;
    assign bus.dir = dir_q;
    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign error   = error_q;
    assign timeout = timeout_q;
    assign seg     = campo_q[0];
    assign min     = campo_q[1];
    assign hora    = campo_q[2];
    assign dia     = campo_q[3];
    assign mes     = campo_q[4];
    assign anio    = campo_q[5];

endmodule
